// File: rtl/rowgen_pkg.sv
// Shared types and sizes for the AXI-Stream row generator.
package rowgen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int LANE_WIDTH        = 32;
    localparam int ROW_BEATS_DEFAULT = 66;
    localparam int ROWS_W            = 32;  // rows_left counter width
    localparam int GAP_W             = 16;  // gap countdown width
    localparam int SEQ_W             = 32;  // accepted-beat sequence width
    localparam int BEAT_W            = 8;   // beat index within a row

endpackage

// File: rtl/axis_rowgen_pattern.sv
// Combinational payload generator: lane i of the beat = seq * LANES + i (mod 2^32).
module axis_rowgen_pattern
    import rowgen_pkg::*;
#(
    parameter int DATA_WIDTH = 256
) (
    input  logic [SEQ_W-1:0]      seq_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam int LANES = DATA_WIDTH / LANE_WIDTH;

    // Fill every 32-bit lane with its counting-pattern value.
    always_comb begin
        data_o = '0;
        for (int i = 0; i < LANES; i++) begin
            data_o[i*LANE_WIDTH +: LANE_WIDTH] = (seq_i * LANE_WIDTH'(LANES)) + LANE_WIDTH'(i);
        end
    end

endmodule

// File: rtl/axis_row_generator.sv
// Command-driven AXI-Stream source emitting rows of ROW_BEATS counting-pattern beats.
// Optional feature macro: ROWGEN_TLAST_EN adds the AXIS_TLAST output.
// Valid/ready: a beat transfers on a cycle where AXIS_TVALID and AXIS_TREADY are both
// high; once AXIS_TVALID rises it, AXIS_TDATA and AXIS_TLAST stay constant until that
// transfer, and AXIS_TVALID never falls without one (stop only acts at row boundaries).
module axis_row_generator
    import rowgen_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int ROW_BEATS  = ROW_BEATS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [ROWS_W-1:0]     row_count,
    input  logic [GAP_W-1:0]      gap_cycles,
    input  logic                  stop,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] AXIS_TDATA,
    output logic                  AXIS_TVALID,
    input  logic                  AXIS_TREADY,
`ifdef ROWGEN_TLAST_EN
    output logic                  AXIS_TLAST,
`endif
    output state_e                dbg_state_o
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(ROW_BEATS - 1);

    state_e                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  tvalid_q, tvalid_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [BEAT_W-1:0]     beat_idx_q, beat_idx_d;
    logic [ROWS_W-1:0]     rows_left_q, rows_left_d;
    logic [SEQ_W-1:0]      seq_q, seq_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic [GAP_W-1:0]      gap_len_q, gap_len_d;
    logic                  stop_pend_q, stop_pend_d;
    logic [DATA_WIDTH-1:0] pat_data;
    logic                  hs;

    // Payload for the next presented beat is derived from the next sequence value.
    axis_rowgen_pattern #(.DATA_WIDTH(DATA_WIDTH)) u_pattern (
        .seq_i  (seq_d),
        .data_o (pat_data)
    );

    assign hs = tvalid_q && AXIS_TREADY;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        tvalid_d    = tvalid_q;
        beat_idx_d  = beat_idx_q;
        rows_left_d = rows_left_q;
        seq_d       = seq_q;
        gap_cnt_d   = gap_cnt_q;
        gap_len_d   = gap_len_q;
        stop_pend_d = stop_pend_q;
        case (state_q)
            IDLE: begin
                busy_d   = 1'b0;
                tvalid_d = 1'b0;
                if (start) begin
                    gap_len_d   = gap_cycles;
                    rows_left_d = row_count;
                    seq_d       = '0;
                    beat_idx_d  = '0;
                    stop_pend_d = 1'b0;
                    if (row_count == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = SEND;
                        busy_d   = 1'b1;
                        tvalid_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (stop) stop_pend_d = 1'b1;
                if (hs) begin
                    seq_d = seq_q + SEQ_W'(1);
                    if (beat_idx_q == LAST_BEAT) begin
                        beat_idx_d  = '0;
                        rows_left_d = rows_left_q - ROWS_W'(1);
                        if (rows_left_q == ROWS_W'(1) || stop_pend_q || stop) begin
                            state_d  = DONE;
                            done_d   = 1'b1;
                            busy_d   = 1'b0;
                            tvalid_d = 1'b0;
                        end else if (gap_len_q != '0) begin
                            state_d   = GAP;
                            tvalid_d  = 1'b0;
                            gap_cnt_d = gap_len_q;
                        end
                    end else begin
                        beat_idx_d = beat_idx_q + BEAT_W'(1);
                    end
                end
            end
            GAP: begin
                if (stop || stop_pend_q) begin
                    stop_pend_d = 1'b1;
                    state_d     = DONE;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    state_d   = SEND;
                    tvalid_d  = 1'b1;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            DONE: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                tvalid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        tdata_d = tvalid_d ? pat_data : '0;
    end

    // State, counters and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            beat_idx_q  <= '0;
            rows_left_q <= '0;
            seq_q       <= '0;
            gap_cnt_q   <= '0;
            gap_len_q   <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            beat_idx_q  <= beat_idx_d;
            rows_left_q <= rows_left_d;
            seq_q       <= seq_d;
            gap_cnt_q   <= gap_cnt_d;
            gap_len_q   <= gap_len_d;
            stop_pend_q <= stop_pend_d;
        end
    end

`ifdef ROWGEN_TLAST_EN
    logic tlast_q;
    // TLAST marks the final beat of a row and is held alongside TDATA.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) tlast_q <= 1'b0;
        else         tlast_q <= tvalid_d && (beat_idx_d == LAST_BEAT);
    end
    assign AXIS_TLAST = tlast_q;
`endif

    assign busy        = busy_q;
    assign done        = done_q;
    assign AXIS_TVALID = tvalid_q;
    assign AXIS_TDATA  = tdata_q;
    assign dbg_state_o = state_q;

endmodule
